// File: rtl/sbox_pkg.sv
// Shared types and constants for the S-box sharing scheduler.
// Tags carry the owning requester id through the fixed-latency core pipe.
package sbox_pkg;

  localparam int unsigned SBOX_W      = 8;
  localparam int unsigned NUM_REQ_MAX = 8;
  localparam int unsigned TAG_IDW     = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } sbox_tag_t;

  localparam logic SBOX_FWD = 1'b0;
  localparam logic SBOX_INV = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Pointer state is owned by the caller.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : p_pick
    logic [IW-1:0] k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      k = IW'((32'(ptr) + off) % N);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/sbox_share_sched.sv
// Round-robin scheduler sharing one pipelined fwd/inv S-box core among NUM_REQ requesters.
// Each issued byte is tagged through a SBOX_LAT+1 deep pipe and steered back to its owner.
module sbox_share_sched
  import sbox_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SBOX_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_inv,
  input  logic [SBOX_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [SBOX_W*NUM_REQ-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [SBOX_W-1:0]         core_in,
  output logic                      core_inv,
  input  logic [SBOX_W-1:0]         core_out,
  output logic                      idle
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        busy_q, busy_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [SBOX_W*NUM_REQ-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [SBOX_W-1:0]         core_in_q, core_in_d;
  logic                      core_inv_q, core_inv_d;
  logic [NUM_REQ-1:0]        elig, gnt;
  logic [IW-1:0]             gnt_idx;
  logic                      gnt_any;
  sbox_tag_t                 pipe_q [SBOX_LAT+1];
  sbox_tag_t                 push, tail;

  // busy spans accept..consume, so a requester can never be re-granted while in flight
  assign elig = req_valid & ~busy_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign tail = pipe_q[SBOX_LAT];

  always_comb begin
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    core_in_d   = core_in_q;
    core_inv_d  = core_inv_q;
    push        = '0;

    if (gnt_any) begin
      rr_ptr_d   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IW'(1);
      push.valid = 1'b1;
      push.id    = TAG_IDW'(gnt_idx);
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        busy_d[i]      = 1'b0;
        rsp_valid_d[i] = 1'b0;
      end
      if (gnt[i]) begin
        busy_d[i]  = 1'b1;
        core_in_d  = req_data[SBOX_W*i +: SBOX_W];
        core_inv_d = req_inv[i];
      end
      // Slot is guaranteed free here: the owner cannot have another op outstanding
      if (tail.valid && (tail.id == TAG_IDW'(i))) begin
        rsp_valid_d[i]                = 1'b1;
        rsp_data_d[SBOX_W*i +: SBOX_W] = core_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
      core_in_q   <= '0;
      core_inv_q  <= SBOX_FWD;
      for (int unsigned i = 0; i <= SBOX_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
      core_in_q   <= core_in_d;
      core_inv_q  <= core_inv_d;
      pipe_q[0]   <= push;
      for (int unsigned i = 1; i <= SBOX_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign core_in   = core_in_q;
  assign core_inv  = core_inv_q;
  assign idle      = ~|busy_q;

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench for sbox_share_sched with a 2-cycle reference AES S-box core.
// Expected results are hand-computed constants from the AES S-box tables.
module tb_sbox_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_inv, rsp_ready;
  logic [31:0] req_data;
  logic [3:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  core_in, core_out;
  logic        core_inv, idle;

  int checks = 0;
  int errors = 0;

  sbox_share_sched #(
    .NUM_REQ  (4),
    .SBOX_LAT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_inv   (req_inv),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .core_in   (core_in),
    .core_inv  (core_inv),
    .core_out  (core_out),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Reference core: GF(2^8) inverse plus AES affine map, two register stages
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x, input logic inv);
    logic [7:0] b;
    if (inv) begin
      return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    end
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  logic [7:0] s1 = 8'h00;
  logic [7:0] s2 = 8'h00;
  always_ff @(posedge clk) begin
    s1 <= sbox_ref(core_in, core_inv);
    s2 <= s1;
  end
  assign core_out = s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    #1;
    while (!idle && n < 20) begin
      cyc();
      #1;
      n++;
    end
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_fair_rdy [10];
  logic [3:0] exp_fair_rv  [10];
  logic [3:0] exp_bp_rdy   [20];
  logic [3:0] exp_b2b_rdy  [6];

  initial begin
    exp_fair_rdy = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    exp_fair_rv  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};
    exp_bp_rdy   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h0, 4'h4, 4'h8, 4'h0,
                     4'h1, 4'h0, 4'h4, 4'h8, 4'h0, 4'h1, 4'h0, 4'h4, 4'h8, 4'h0};
    exp_b2b_rdy  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4};

    rst       = 1'b1;
    req_valid = '0;
    req_inv   = '0;
    req_data  = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready", {28'd0, req_ready}, 32'h0);
    check("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_core_in", {24'd0, core_in}, 32'h0);
    check("rst_core_inv", {31'd0, core_inv}, 32'h0);
    check("rst_idle", {31'd0, idle}, 32'h1);
    rst = 1'b0;

    // Single forward request from requester 2
    cyc();
    req_valid = 4'b0100;
    req_data  = 32'h0053_0000;
    rsp_ready = 4'hf;
    #1;
    check("single_grant", {28'd0, req_ready}, 32'h4);
    cyc();
    req_valid = '0;
    #1;
    check("single_core_in", {24'd0, core_in}, 32'h53);
    check("single_core_inv", {31'd0, core_inv}, 32'h0);
    check("single_busy", {31'd0, idle}, 32'h0);
    check("single_rv_t1", {28'd0, rsp_valid}, 32'h0);
    cyc();
    cyc();
    #1;
    check("single_rv_t3", {28'd0, rsp_valid}, 32'h0);
    cyc();
    #1;
    check("single_rv_t4", {28'd0, rsp_valid}, 32'h4);
    check("single_data", {24'd0, rsp_data[23:16]}, 32'hed);
    cyc();
    #1;
    check("single_rv_done", {28'd0, rsp_valid}, 32'h0);
    check("single_idle", {31'd0, idle}, 32'h1);

    // Inverse request from requester 0
    cyc();
    req_valid = 4'b0001;
    req_inv   = 4'b0001;
    req_data  = 32'h0000_00ed;
    #1;
    check("inv_grant", {28'd0, req_ready}, 32'h1);
    cyc();
    req_valid = '0;
    #1;
    check("inv_core_in", {24'd0, core_in}, 32'hed);
    check("inv_core_inv", {31'd0, core_inv}, 32'h1);
    cyc();
    cyc();
    cyc();
    #1;
    check("inv_rv", {28'd0, rsp_valid}, 32'h1);
    check("inv_data", {24'd0, rsp_data[7:0]}, 32'h53);
    cyc();
    #1;
    check("inv_idle", {31'd0, idle}, 32'h1);

    // Fairness from reset: all valid, immediate consumption
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    req_inv   = '0;
    req_data  = 32'hff10_0100;
    req_valid = 4'hf;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("fair_rdy_%0d", c), {28'd0, req_ready}, {28'd0, exp_fair_rdy[c]});
      check($sformatf("fair_rv_%0d", c), {28'd0, rsp_valid}, {28'd0, exp_fair_rv[c]});
      if (c == 7) check("fair_data", rsp_data, 32'h16ca_7c63);
      cyc();
    end
    req_valid = '0;
    wait_idle("fair_idle");

    // Backpressure on requester 1
    cyc();
    req_data  = 32'hff10_2000;
    rsp_ready = 4'b1101;
    req_valid = 4'hf;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("bp_rdy_%0d", c), {28'd0, req_ready}, {28'd0, exp_bp_rdy[c]});
      if (c >= 5) begin
        check($sformatf("bp_rv1_%0d", c), {31'd0, rsp_valid[1]}, 32'h1);
        check($sformatf("bp_data1_%0d", c), {24'd0, rsp_data[15:8]}, 32'hb7);
      end
      cyc();
    end
    rsp_ready = 4'hf;
    req_valid = '0;
    wait_idle("bp_idle");
    check("bp_rv_clear", {28'd0, rsp_valid}, 32'h0);

    // Reset one cycle after accepting 0x00 from requester 3
    cyc();
    req_valid = 4'b1000;
    req_data  = 32'h0;
    #1;
    check("rmf_grant", {28'd0, req_ready}, 32'h8);
    cyc();
    req_valid = '0;
    check("rmf_busy", {31'd0, idle}, 32'h0);
    rst = 1'b1;
    #1;
    check("rmf_idle", {31'd0, idle}, 32'h1);
    check("rmf_rsp_data", rsp_data, 32'h0);
    check("rmf_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    check("rmf_core_in", {24'd0, core_in}, 32'h0);
    check("rmf_core_inv", {31'd0, core_inv}, 32'h0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rmf_no_rv_%0d", c), {28'd0, rsp_valid}, 32'h0);
      cyc();
    end
    req_valid = 4'hf;
    #1;
    check("rmf_ptr", {28'd0, req_ready}, 32'h1);
    req_valid = '0;

    // Back-to-back on requester 2
    cyc();
    req_valid = 4'b0100;
    req_data  = 32'h0053_0000;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("b2b_rdy_%0d", c), {28'd0, req_ready}, {28'd0, exp_b2b_rdy[c]});
      if (c == 1) req_data = 32'h0010_0000;
      if (c == 4) begin
        check("b2b_rv", {28'd0, rsp_valid}, 32'h4);
        check("b2b_data0", {24'd0, rsp_data[23:16]}, 32'hed);
      end
      cyc();
    end
    req_valid = '0;
    cyc();
    cyc();
    cyc();
    #1;
    check("b2b_rv2", {28'd0, rsp_valid}, 32'h4);
    check("b2b_data1", {24'd0, rsp_data[23:16]}, 32'hca);
    wait_idle("b2b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
